// File: rtl/regs_pkg.sv
// regs_pkg: shared state encoding and init-value helper for the multiport register file
package regs_pkg;
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
  localparam int INIT_ZERO = 0;
  localparam int INIT_INDEX = 1;
  function automatic logic [63:0] init_value(input logic [31:0] idx, input int mode);
    return mode == INIT_INDEX ? 64'(idx) : 64'd0;
  endfunction
endpackage

// File: rtl/regs_multiport_if.sv
// regs_multiport_if: decode/writeback-facing bus of the multiport register file
interface regs_multiport_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic regWrite;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic [NUM_RD*ADDR_W-1:0] readReg;
  logic [NUM_RD*DATA_W-1:0] readData;
  logic clearReq;
  logic ready;
  modport master (output regWrite, writeReg, writeData, readReg, clearReq, input readData, ready);
  modport slave (input regWrite, writeReg, writeData, readReg, clearReq, output readData, ready);
endinterface

// File: rtl/regs_read_port.sv
// regs_read_port: one registered read port with range check, zero-reg mask and write bypass
module regs_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic [ADDR_W-1:0] rdAddr,
  input  logic wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  output logic [DATA_W-1:0] rdData
);
  logic valid;
  logic [DATA_W-1:0] nextData;
  assign valid = 32'(rdAddr) < NUM_REGS && !(ZERO_REG != 0 && rdAddr == '0);
  // wrEn is already qualified, so a suppressed write never bypasses
  assign nextData = !en || !valid ? '0 : wrEn && wrAddr == rdAddr ? wrData : regs[rdAddr];
  always_ff @(posedge clock or negedge reset)
    if (!reset) rdData <= '0;
    else rdData <= nextData;
endmodule

// File: rtl/regs_multiport.sv
// regs_multiport: N-read/1-write register file with hardware init sequencer
module regs_multiport
  import regs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD = 2,
  parameter int ZERO_REG = 1,
  parameter int INIT_MODE = 1
) (
  input logic clock,
  input logic reset,
  regs_multiport_if.slave bus
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rdData [NUM_RD];
  state_t state;
  logic [ADDR_W-1:0] initPtr;
  logic run, last, wrEn;
  assign run = state == ST_RUN;
  assign last = 32'(initPtr) == NUM_REGS - 1;
  // a write in the clearReq cycle is discarded along with any bypass
  assign wrEn = run && !bus.clearReq && bus.regWrite && 32'(bus.writeReg) < NUM_REGS &&
                !(ZERO_REG != 0 && bus.writeReg == '0);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= ST_INIT;
      initPtr <= '0;
      bus.ready <= 1'b0;
    end else if (!run) begin
      state <= last ? ST_RUN : ST_INIT;
      bus.ready <= last;
      initPtr <= last ? initPtr : initPtr + 1'b1;
    end else if (bus.clearReq) begin
      state <= ST_INIT;
      initPtr <= '0;
      bus.ready <= 1'b0;
    end
  always_ff @(posedge clock)
    if (!run) regs[initPtr] <= DATA_W'(init_value(32'(initPtr), INIT_MODE));
    else if (wrEn) regs[bus.writeReg] <= bus.writeData;
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regs_read_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .NUM_REGS(NUM_REGS),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .clock(clock),
      .reset(reset),
      .en(run),
      .rdAddr(bus.readReg[i*ADDR_W +: ADDR_W]),
      .wrEn(wrEn),
      .wrAddr(bus.writeReg),
      .wrData(bus.writeData),
      .regs(regs),
      .rdData(rdData[i])
    );
  end
  always_comb
    for (int k = 0; k < NUM_RD; k++) bus.readData[k*DATA_W +: DATA_W] = rdData[k];
endmodule

// File: tb/tb_regs_multiport.sv
// tb_regs_multiport: directed checks of init, read/write, bypass, clear and reset behaviour
module tb_regs_multiport;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int n;
  regs_multiport_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) busA ();
  regs_multiport_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) busB ();
  regs_multiport #(.NUM_REGS(32), .INIT_MODE(1)) dutA (.clock(clock), .reset(reset), .bus(busA));
  regs_multiport #(.NUM_REGS(24), .INIT_MODE(1)) dutB (.clock(clock), .reset(reset), .bus(busB));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic waitReady(output int cnt);
    cnt = 0;
    while (!busA.ready && cnt < 100) begin
      step();
      cnt++;
    end
  endtask
  function automatic logic [31:0] rdA(input int k);
    return busA.readData[k*32 +: 32];
  endfunction
  initial begin
    busA.regWrite = 0; busA.writeReg = 0; busA.writeData = 0; busA.readReg = 0; busA.clearReq = 0;
    busB.regWrite = 0; busB.writeReg = 0; busB.writeData = 0; busB.readReg = 0; busB.clearReq = 0;
    #12;
    check("rst_ready", 32'(busA.ready), 0);
    check("rst_rd0", rdA(0), 0);
    check("rst_rd1", rdA(1), 0);
    reset = 1;
    n = 0;
    while (!busB.ready && n < 100) begin
      step();
      n++;
      check("init_rd_zero", rdA(0), 0);
    end
    check("readyB_edges", 32'(n), 24);
    waitReady(n);
    check("readyA_edges", 32'(n + 24), 32);
    busA.readReg = {5'd31, 5'd5};
    step();
    check("init_r5", rdA(0), 5);
    check("init_r31", rdA(1), 31);
    busA.readReg = {5'd0, 5'd0};
    step();
    check("zero_r0", rdA(0), 0);
    busA.regWrite = 1; busA.writeReg = 7; busA.writeData = 32'hDEADBEEF;
    step();
    busA.regWrite = 0; busA.readReg = {5'd7, 5'd7};
    step();
    check("wr7_p0", rdA(0), 32'hDEADBEEF);
    check("wr7_p1", rdA(1), 32'hDEADBEEF);
    busA.regWrite = 1; busA.writeReg = 9; busA.writeData = 32'h12345678; busA.readReg = {5'd7, 5'd9};
    step();
    check("bypass9", rdA(0), 32'h12345678);
    check("other7", rdA(1), 32'hDEADBEEF);
    busA.regWrite = 0;
    step();
    check("after9", rdA(0), 32'h12345678);
    busA.regWrite = 1; busA.writeReg = 0; busA.writeData = 32'hFFFFFFFF; busA.readReg = {5'd0, 5'd0};
    step();
    check("wr0_bypass", rdA(0), 0);
    busA.regWrite = 0;
    step();
    check("wr0_later", rdA(1), 0);
    busA.regWrite = 1; busA.writeReg = 3; busA.writeData = 32'hAAAA;
    step();
    busA.regWrite = 1; busA.writeReg = 3; busA.writeData = 32'h5555; busA.readReg = {5'd7, 5'd3};
    busA.clearReq = 1;
    step();
    check("clr_read", rdA(0), 32'hAAAA);
    check("clr_ready", 32'(busA.ready), 0);
    busA.clearReq = 0; busA.regWrite = 0;
    step();
    check("clr_rd_zero", rdA(0), 0);
    check("clr_rd1_zero", rdA(1), 0);
    waitReady(n);
    check("clr_edges", 32'(n + 1), 32);
    step();
    check("clr_r3", rdA(0), 3);
    check("clr_r7", rdA(1), 7);
    reset = 0;
    #1;
    check("run_rst_rd", rdA(0), 0);
    check("run_rst_ready", 32'(busA.ready), 0);
    #3 reset = 1;
    for (int i = 0; i < 10; i++) step();
    check("mid_ready", 32'(busA.ready), 0);
    reset = 0;
    #1;
    check("mid_rst_rd", rdA(1), 0);
    #3 reset = 1;
    waitReady(n);
    check("rerun_edges", 32'(n), 32);
    while (!busB.ready) step();
    busB.regWrite = 1; busB.writeReg = 30; busB.writeData = 32'hCAFEF00D; busB.readReg = {5'd23, 5'd30};
    step();
    check("b_r30_bypass", busB.readData[31:0], 0);
    check("b_r23", busB.readData[63:32], 23);
    busB.regWrite = 0;
    step();
    check("b_r30_later", busB.readData[31:0], 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
